// File: rtl/ifs_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        DONE    = 3'd5
    } ifs_state_t;

    localparam logic LH_LO = 1'b0;
    localparam logic LH_HI = 1'b1;

    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/ifs_wait_timer.sv
// Memory-latency down-counter: load, decrement to zero, flag the last count and zero.
module ifs_wait_timer
    import ifs_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetches a 16-bit instruction as two bytes from program memory into the IR and owns the PC.
// Optional: define IFS_BIG_ENDIAN_EN to route the lower-address byte to the IR high half.
//
// state   | meaning
// IDLE    | waiting for Start
// REQ_LO  | first byte read strobe, PC advances
// WAIT_LO | waiting on memory latency for the first byte
// REQ_HI  | second byte read strobe, first byte written to IR
// WAIT_HI | waiting for the second byte, then its IR write cycle
// DONE    | Done pulse, IR holds the full word
module instruction_fetch_sequencer
    import ifs_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [7:0]        MemData,
    output logic [7:0]        IR_I,
    output logic              IR_LH,
    output logic              IR_Write,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Done
);

`ifdef IFS_BIG_ENDIAN_EN
    localparam logic FIRST_LH = LH_HI;
`else
    localparam logic FIRST_LH = LH_LO;
`endif
    localparam logic SECOND_LH = ~FIRST_LH;

    localparam int              LAT_CLAMP = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] LAT      = CNT_W'(LAT_CLAMP);

    ifs_state_t        state;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend_vld;
    logic [ADDR_W-1:0] start_addr;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic              tmr_last;

    // A PCLoad arriving with Start redirects the very first read.
    assign start_addr = PCLoad ? PCIn : PC;
    assign tmr_load   = (state == REQ_LO) || (state == REQ_HI);
    assign tmr_dec    = (state == WAIT_LO) || (state == WAIT_HI);

    ifs_wait_timer u_wait_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (tmr_load),
        .load_val (LAT),
        .dec      (tmr_dec),
        .zero     (tmr_zero),
        .last     (tmr_last)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            PC       <= RESET_PC;
            pend_pc  <= '0;
            pend_vld <= 1'b0;
            MemRead  <= 1'b0;
            MemAddr  <= '0;
            IR_I     <= '0;
            IR_LH    <= 1'b0;
            IR_Write <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            MemRead  <= 1'b0;
            IR_Write <= 1'b0;
            Done     <= 1'b0;

            if (Busy && PCLoad) begin
                pend_pc  <= PCIn;
                pend_vld <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (PCLoad) begin
                        PC <= PCIn;
                    end
                    if (Start) begin
                        state   <= REQ_LO;
                        Busy    <= 1'b1;
                        MemRead <= 1'b1;
                        MemAddr <= start_addr;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ_LO: begin
                    PC    <= PC + ADDR_W'(1);
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (tmr_last) begin
                        IR_I     <= MemData;
                        IR_LH    <= FIRST_LH;
                        IR_Write <= 1'b1;
                        state    <= REQ_HI;
                        MemRead  <= 1'b1;
                        MemAddr  <= PC;
                    end
                end
                REQ_HI: begin
                    PC    <= PC + ADDR_W'(1);
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tmr_last) begin
                        IR_I     <= MemData;
                        IR_LH    <= SECOND_LH;
                        IR_Write <= 1'b1;
                    end else if (tmr_zero) begin
                        // High-byte write cycle; a pending PC load overrides the +2 result here.
                        state    <= DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        pend_vld <= 1'b0;
                        if (PCLoad) begin
                            PC <= PCIn;
                        end else if (pend_vld) begin
                            PC <= pend_pc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Scoreboard bench for instruction_fetch_sequencer: directed cases then randomized Start/PCLoad/reset traffic.
module tb_instruction_fetch_sequencer;

    localparam int         ADDR_W = 8;
    localparam int         L      = 3;
    localparam logic [7:0] RST_PC = 8'h00;
`ifdef IFS_BIG_ENDIAN_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic       Clock  = 1'b0;
    logic       Reset  = 1'b1;
    logic       Start  = 1'b0;
    logic       PCLoad = 1'b0;
    logic [7:0] PCIn   = 8'h00;
    logic [7:0] MemData = 8'h00;
    logic       MemRead, IR_LH, IR_Write, Busy, Done;
    logic [7:0] MemAddr, IR_I, PC;

    always #5 Clock = ~Clock;

    instruction_fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .MEM_LAT  (L),
        .RESET_PC (RST_PC)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .PCLoad   (PCLoad),
        .PCIn     (PCIn),
        .MemRead  (MemRead),
        .MemAddr  (MemAddr),
        .MemData  (MemData),
        .IR_I     (IR_I),
        .IR_LH    (IR_LH),
        .IR_Write (IR_Write),
        .PC       (PC),
        .Busy     (Busy),
        .Done     (Done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] val;
        logic       lh;
    } ev_t;

    ev_t        wq[$];
    ev_t        rq[$];
    ev_t        dq[$];
    ev_t        me;
    logic [7:0] mem [256];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected DUT output (cycle %0d)", name, cyc);
    endtask

    // Memory: data for a read in cycle c appears in cycle c+L, random filler otherwise.
    logic       lv [8] = '{default: 1'b0};
    logic [7:0] la [8] = '{default: 8'h00};

    always @(negedge Clock) begin
        for (int i = 7; i > 0; i--) begin
            lv[i] = lv[i-1];
            la[i] = la[i-1];
        end
        lv[0] = MemRead;
        la[0] = MemAddr;
    end

    always @(posedge Clock) begin
        #1;
        MemData = lv[L-1] ? mem[la[L-1]] : 8'($urandom);
    end

    always @(negedge Clock) begin
        if (mon_en) begin
            if (MemRead) begin
                if (rq.size() == 0) unexp("memread");
                else begin
                    me = rq.pop_front();
                    chk("rd_cycle", cyc, me.cyc);
                    chk("rd_addr", int'(MemAddr), int'(me.val));
                end
            end
            if (IR_Write) begin
                if (wq.size() == 0) unexp("ir_write");
                else begin
                    me = wq.pop_front();
                    chk("wr_cycle", cyc, me.cyc);
                    chk("wr_data", int'(IR_I), int'(me.val));
                    chk("wr_lh", int'(IR_LH), int'(me.lh));
                end
            end
            if (Done) begin
                if (dq.size() == 0) unexp("done");
                else begin
                    me = dq.pop_front();
                    chk("done_cycle", cyc, me.cyc);
                    chk("done_pc", int'(PC), int'(me.val));
                end
            end
        end
    end

    // Reference model: a fetch started in cycle t occupies t+1..t+3+2L and reports Done at t+4+2L.
    bit         act    = 1'b0;
    int         t0     = 0;
    logic [7:0] fpc    = 8'h00;
    logic [7:0] mpc    = RST_PC;
    logic [7:0] pend   = 8'h00;
    bit         pend_v = 1'b0;

    task automatic step(input bit st, input bit ld, input logic [7:0] pin, input bit rst = 1'b0);
        int c;
        @(posedge Clock);
        #1;
        Start  = st;
        PCLoad = ld;
        PCIn   = pin;
        Reset  = rst;
        c = cyc;
        if (act && c >= t0 + 4 + 2 * L) begin
            act    = 1'b0;
            mpc    = pend_v ? pend : 8'(fpc + 8'd2);
            pend_v = 1'b0;
            dq.push_back('{t0 + 4 + 2 * L, mpc, 1'b0});
        end
        if (mon_en) begin
            chk("busy", int'(Busy), int'(act));
            if (!act) chk("pc_idle", int'(PC), int'(mpc));
        end
        if (rst) begin
            while (wq.size() > 0 && wq[wq.size()-1].cyc > c) void'(wq.pop_back());
            while (rq.size() > 0 && rq[rq.size()-1].cyc > c) void'(rq.pop_back());
            while (dq.size() > 0 && dq[dq.size()-1].cyc > c) void'(dq.pop_back());
            act    = 1'b0;
            pend_v = 1'b0;
            mpc    = RST_PC;
            return;
        end
        if (act) begin
            if (ld) begin
                pend   = pin;
                pend_v = 1'b1;
            end
        end else begin
            if (ld) mpc = pin;
            if (st) begin
                act = 1'b1;
                t0  = c;
                fpc = mpc;
                rq.push_back('{c + 1, fpc, 1'b0});
                rq.push_back('{c + 2 + L, 8'(fpc + 8'd1), 1'b0});
                wq.push_back('{c + 2 + L, mem[fpc], BE});
                wq.push_back('{c + 3 + 2 * L, mem[8'(fpc + 8'd1)], !BE});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] pin;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h34;
        mem[8'h11] = 8'h12;
        mem[8'hFF] = 8'hAA;
        mem[8'h00] = 8'hBB;

        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk("rst_memread", int'(MemRead), 0);
        chk("rst_memaddr", int'(MemAddr), 0);
        chk("rst_ir_i", int'(IR_I), 0);
        chk("rst_ir_lh", int'(IR_LH), 0);
        chk("rst_ir_write", int'(IR_Write), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_pc", int'(PC), int'(RST_PC));
        mon_en = 1'b1;

        // Basic fetch from 0x10.
        step(1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * L + 6);

        // Wrap from 0xFF.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * L + 6);

        // Pending PC load mid-fetch, ignored Start while busy, back-to-back Start in the Done cycle.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 2 * L + 3; k++) step(k == 3, k == 2, 8'h40);
        step(1'b1, 1'b0, 8'h00);
        idle(2 * L + 6);

        // Reset in the low-byte write cycle.
        step(1'b1, 1'b0, 8'h00);
        idle(L + 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        chk("abort_pc", int'(PC), int'(RST_PC));
        idle(2 * L + 6);

        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 3))
                0:       pin = 8'hFF;
                1:       pin = 8'hFE;
                default: pin = 8'($urandom);
            endcase
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, pin,
                 $urandom_range(0, 299) == 0);
        end
        idle(2 * L + 8);

        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
